dff_pipe: RTL and testbench

Parametrised register pipeline: a chain of DEPTH enabled, synchronously reset flip-flop stages of WIDTH bits, each carrying a valid flag. It is the multi-bit, multi-stage successor to the single-bit reset flop and is used wherever the lab datapaths need a fixed, stall-able delay with occupancy tracking, for example to align control with multi-cycle arithmetic.

---
 rtl/dff_pipe_pkg.sv | 8 +
 rtl/d_ff_en.sv | 24 ++
 rtl/dff_pipe.sv | 55 +++++
 tb/tb_dff_pipe.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: default sizes and occupancy-counter width helper for dff_pipe
package dff_pipe_pkg;
  localparam int DFF_PIPE_WIDTH_DEF = 8;
  localparam int DFF_PIPE_DEPTH_DEF = 4;
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/d_ff_en.sv
// d_ff_en: one enabled pipeline stage with valid flag, sync reset and clear
module d_ff_en #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             vd,
  output logic [WIDTH-1:0] q,
  output logic             vq
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q  <= RST_VAL;
      vq <= 1'b0;
    end else if (en) begin
      q  <= d;
      vq <= vd;
    end
  end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: stall-able DEPTH-stage register pipeline with occupancy count; DFF_PIPE_TAP_EN adds taps/tap_valid
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
  parameter int DEPTH = DFF_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int OW = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic [OW-1:0]    occ
`ifdef DFF_PIPE_TAP_EN
  ,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_valid
`endif
);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  for (genvar i = 0; i < DEPTH; i++) begin : g
    logic [WIDTH-1:0] din;
    logic             vin;
    if (i == 0) begin : h
      assign din = d;
      assign vin = in_valid;
    end else begin : h
      assign din = data[i-1];
      assign vin = vld[i-1];
    end
    d_ff_en #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk(clk), .rst(rst), .clr(clr), .en(en),
      .d(din), .vd(vin), .q(data[i]), .vq(vld[i])
    );
`ifdef DFF_PIPE_TAP_EN
    assign taps[i*WIDTH +: WIDTH] = data[i];
`endif
  end
`ifdef DFF_PIPE_TAP_EN
  assign tap_valid = vld;
`endif
  assign q         = data[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
  // entering valid adds one, leaving valid removes one; both at once cancel
  always_ff @(posedge clk) begin
    if (rst || clr) occ <= '0;
    else if (en) occ <= occ + OW'(in_valid) - OW'(vld[DEPTH-1]);
  end
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (DEPTH=4 and DEPTH=1 instances)
module tb_dff_pipe;
  logic clk = 1'b0;
  logic rst, en, clr, iv;
  logic [7:0] d, q0;
  logic ov0;
  logic [2:0] occ0;
  logic en1, iv1;
  logic [7:0] d1, q1;
  logic ov1;
  logic [0:0] occ1;
`ifdef DFF_PIPE_TAP_EN
  logic [31:0] taps0;
  logic [3:0]  tv0;
  logic [7:0]  taps1;
  logic [0:0]  tv1;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic adv = 1'b0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(iv), .d(d),
    .q(q0), .out_valid(ov0), .occ(occ0)
`ifdef DFF_PIPE_TAP_EN
    , .taps(taps0), .tap_valid(tv0)
`endif
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'hA5)) u1 (
    .clk(clk), .rst(rst), .en(en1), .clr(1'b0), .in_valid(iv1), .d(d1),
    .q(q1), .out_valid(ov1), .occ(occ1)
`ifdef DFF_PIPE_TAP_EN
    , .taps(taps1), .tap_valid(tv1)
`endif
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic v, input logic [7:0] dd);
    en = e; clr = c; iv = v; d = dd;
    @(posedge clk);
    if (c) sb.delete();
    else if (e && v) sb.push_back(dd);
    adv = e | c;
    #1;
  endtask

  // a fresh output word exists only in the cycle after an advancing edge
  always @(negedge clk) begin
    if (adv && ov0 === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected", {24'h0, q0}, 32'hFFFF_FFFF);
      else chk("sb_q", {24'h0, q0}, {24'h0, sb.pop_front()});
    end
  end

  initial begin
    logic [2:0] bub_occ [8];
    bub_occ = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    rst = 1'b1; en = 1'b1; clr = 1'b0; iv = 1'b1; d = 8'hFF;
    en1 = 1'b1; iv1 = 1'b1; d1 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", {24'h0, q0}, 32'hA5);
    chk("rst_ov", {31'h0, ov0}, 32'h0);
    chk("rst_occ", {29'h0, occ0}, 32'h0);
    chk("rst_q1", {24'h0, q1}, 32'hA5);
    rst = 1'b0; en1 = 1'b0; iv1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 1, 8'(i));
      chk("stream_occ", {29'h0, occ0}, (i < 4) ? i : 4);
      if (i == 4) begin
        chk("stream_first_q", {24'h0, q0}, 32'h1);
        chk("stream_first_ov", {31'h0, ov0}, 32'h1);
`ifdef DFF_PIPE_TAP_EN
        chk("taps4", taps0, 32'h0102_0304);
        chk("tv4", {28'h0, tv0}, 32'hF);
`endif
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'hEE);
      chk("stall_q", {24'h0, q0}, 32'h2);
      chk("stall_ov", {31'h0, ov0}, 32'h1);
      chk("stall_occ", {29'h0, occ0}, 32'h4);
    end
    for (int i = 6; i <= 8; i++) step(1, 0, 1, 8'(i));
    repeat (4) step(1, 0, 0, 8'h00);
    chk("drain_occ", {29'h0, occ0}, 32'h0);
    chk("drain_sb", sb.size(), 0);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) step(1, 0, (k % 2) == 1, 8'(9 + k));
      else step(1, 0, 0, 8'h00);
      chk("bub_occ", {29'h0, occ0}, {29'h0, bub_occ[k-1]});
      if (k >= 4 && k <= 7) begin
        chk("bub_ov", {31'h0, ov0}, (k % 2) == 0);
        chk("bub_q", {24'h0, q0}, 32'(6 + k));
      end
    end
    for (int i = 20; i <= 22; i++) step(1, 0, 1, 8'(i));
    chk("pre_flush_occ", {29'h0, occ0}, 32'h3);
    step(1, 1, 1, 8'h77);
    chk("flush_occ", {29'h0, occ0}, 32'h0);
    chk("flush_ov", {31'h0, ov0}, 32'h0);
    chk("flush_q", {24'h0, q0}, 32'hA5);
    repeat (4) begin
      step(1, 0, 0, 8'h00);
      chk("post_flush_ov", {31'h0, ov0}, 32'h0);
    end
    step(1, 0, 1, 8'h42);
    repeat (4) step(1, 0, 0, 8'h00);
    chk("final_sb", sb.size(), 0);
    chk("final_occ", {29'h0, occ0}, 32'h0);
    en = 1'b0;
    en1 = 1'b1; iv1 = 1'b1; d1 = 8'h3C;
    @(posedge clk); #1;
    chk("d1_q", {24'h0, q1}, 32'h3C);
    chk("d1_ov", {31'h0, ov1}, 32'h1);
    chk("d1_occ", {31'h0, occ1}, 32'h1);
`ifdef DFF_PIPE_TAP_EN
    chk("d1_taps", {24'h0, taps1}, 32'h3C);
    chk("d1_tv", {31'h0, tv1}, 32'h1);
`endif
    iv1 = 1'b0; d1 = 8'h00;
    @(posedge clk); #1;
    chk("d1_occ0", {31'h0, occ1}, 32'h0);
    chk("d1_ov0", {31'h0, ov1}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
